// File: rtl/bmp_stream_loader.sv
// Autonomous BMP loader: parses the header from BMP ROM, validates it and streams bfSize bytes into RAM.
// Optional BGRA->RGBA swap for 32-bpp images is compiled in with `define BMP_CHANNEL_SWAP_EN.
module bmp_stream_loader #(
  parameter int BYTE_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int MAX_BYTES  = 786486
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          rom_rd_en,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [BYTE_WIDTH-1:0]         rom_rdata,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [LANES*BYTE_WIDTH-1:0]   ram_wdata,
  input  logic                          ram_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   img_width,
  output logic [31:0]                   img_height,
  output logic [31:0]                   pix_offset,
  output logic [15:0]                   bit_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CHECK, S_COPY, S_DONE, S_ERR
  } state_t;

  state_t r_state, w_next;

  logic [31:0]                 r_rd_ptr;
  logic [31:0]                 r_rd_addr;
  logic                        r_rd_vld;
  logic [31:0]                 r_pk_cnt;
  logic [BYTE_WIDTH-1:0]       r_skid;
  logic                        r_skid_vld;
  logic [2:0]                  r_lane;
  logic                        r_wr_en;
  logic [ADDR_WIDTH-1:0]       r_wr_addr;
  logic [LANES*BYTE_WIDTH-1:0] r_wdata;
  logic [15:0]                 r_sig;
  logic [31:0]                 r_bfsize;
  logic [31:0]                 r_offset;
  logic [31:0]                 r_width;
  logic [31:0]                 r_height;
  logic [15:0]                 r_bpp;
  logic                        r_err;

  logic                        w_accept;
  logic                        w_out_free;
  logic                        w_byte_vld;
  logic [BYTE_WIDTH-1:0]       w_byte;
  logic                        w_take;
  logic                        w_skid_next;
  logic                        w_last_byte;
  logic                        w_rd_issue;
  logic                        w_hdr_vld;
  logic                        w_bad;
  logic [1:0]                  w_sub;
  logic [ADDR_WIDTH-1:0]       w_phys;

  assign w_accept    = r_wr_en & ram_ready;
  assign w_out_free  = ~r_wr_en | w_accept;
  assign w_byte_vld  = (r_state == S_COPY) & (r_skid_vld | r_rd_vld);
  assign w_byte      = r_skid_vld ? r_skid : rom_rdata;
  assign w_take      = w_byte_vld & w_out_free;
  // A byte that cannot be packed parks in the skid; no new read is issued while that happens.
  assign w_skid_next = w_byte_vld & ~w_take;
  assign w_last_byte = (r_pk_cnt == r_bfsize - 32'd1);
  assign w_rd_issue  = ((r_state == S_HDR) & (r_rd_ptr < 32'd30)) |
                       ((r_state == S_COPY) & ~w_skid_next & (r_rd_ptr < r_bfsize));
  assign w_hdr_vld   = (r_state == S_HDR) & r_rd_vld & (r_rd_addr < 32'd30);
  assign w_sub       = r_rd_addr[1:0] - 2'd2;
  assign w_bad       = (r_sig != 16'h4D42) | (r_bfsize < 32'd30) |
                       (r_bfsize > 32'(MAX_BYTES)) | (r_offset >= r_bfsize);

  // Channel swap is done by remapping the read address, so packing and timing are untouched.
  always_comb begin
    w_phys = r_rd_ptr[ADDR_WIDTH-1:0];
`ifdef BMP_CHANNEL_SWAP_EN
    if ((r_state == S_COPY) && (r_bpp == 16'd32) && (r_rd_ptr >= r_offset)) begin
      if (((r_rd_ptr[1:0] - r_offset[1:0]) == 2'd0) && ((r_rd_ptr + 32'd2) < r_bfsize))
        w_phys = r_rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
      else if ((r_rd_ptr[1:0] - r_offset[1:0]) == 2'd2)
        w_phys = r_rd_ptr[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_HDR;
      S_HDR:   if (r_rd_vld && (r_rd_addr == 32'd29)) w_next = S_CHECK;
      S_CHECK: w_next = w_bad ? S_ERR : S_COPY;
      S_COPY:  if (w_accept && (r_pk_cnt == r_bfsize)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rd_addr  <= '0;
      r_rd_vld   <= 1'b0;
      r_pk_cnt   <= '0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_lane     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wdata    <= '0;
      r_sig      <= '0;
      r_bfsize   <= '0;
      r_offset   <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_bpp      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_addr <= r_rd_ptr;
        r_rd_ptr  <= r_rd_ptr + 32'd1;
      end
      if ((r_state == S_IDLE) && start) begin
        r_err      <= 1'b0;
        r_rd_ptr   <= '0;
        r_pk_cnt   <= '0;
        r_lane     <= '0;
        r_skid_vld <= 1'b0;
        r_wr_en    <= 1'b0;
        r_wr_addr  <= '0;
        r_wdata    <= '0;
        r_sig      <= '0;
        r_bfsize   <= '0;
        r_offset   <= '0;
        r_width    <= '0;
        r_height   <= '0;
        r_bpp      <= '0;
      end
      if (r_state == S_CHECK) begin
        r_rd_ptr <= '0;
        if (w_bad) r_err <= 1'b1;
      end
      if (w_hdr_vld) begin
        if (r_rd_addr < 32'd2)
          r_sig[{r_rd_addr[0], 3'b000} +: 8] <= rom_rdata[7:0];
        else if (r_rd_addr >= 32'd2 && r_rd_addr < 32'd6)
          r_bfsize[{w_sub, 3'b000} +: 8] <= rom_rdata[7:0];
        else if (r_rd_addr >= 32'd10 && r_rd_addr < 32'd14)
          r_offset[{w_sub, 3'b000} +: 8] <= rom_rdata[7:0];
        else if (r_rd_addr >= 32'd18 && r_rd_addr < 32'd22)
          r_width[{w_sub, 3'b000} +: 8] <= rom_rdata[7:0];
        else if (r_rd_addr >= 32'd22 && r_rd_addr < 32'd26)
          r_height[{w_sub, 3'b000} +: 8] <= rom_rdata[7:0];
        else if (r_rd_addr >= 32'd28)
          r_bpp[{r_rd_addr[0], 3'b000} +: 8] <= rom_rdata[7:0];
      end
      if (r_state == S_COPY) begin
        r_skid_vld <= w_skid_next;
        if (w_skid_next) r_skid <= w_byte;
        if (w_accept) begin
          r_wr_en   <= 1'b0;
          r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
        end
        if (w_take) begin
          if (r_lane == 3'd0)
            r_wdata <= (LANES*BYTE_WIDTH)'(w_byte);
          else
            r_wdata[int'(r_lane)*BYTE_WIDTH +: BYTE_WIDTH] <= w_byte;
          r_pk_cnt <= r_pk_cnt + 32'd1;
          if ((r_lane == 3'(LANES-1)) || w_last_byte) begin
            r_wr_en <= 1'b1;
            r_lane  <= '0;
          end else begin
            r_lane <= r_lane + 3'd1;
          end
        end
      end
    end
  end

  assign rom_rd_en  = w_rd_issue;
  assign rom_addr   = w_phys;
  assign ram_wr_en  = r_wr_en;
  assign ram_addr   = r_wr_addr;
  assign ram_wdata  = r_wdata;
  assign busy       = (r_state == S_HDR) | (r_state == S_CHECK) | (r_state == S_COPY);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign img_width  = r_width;
  assign img_height = r_height;
  assign pix_offset = r_offset;
  assign bit_count  = r_bpp;

endmodule

// File: doc/bmp_stream_loader.md
Name: bmp_stream_loader

Overview:
Autonomous BMP loader that copies an image from the byte-wide BMP ROM into the BMP RAM without testbench involvement. It parses the BMP file header, publishes the image geometry, validates the file, and streams all `bfSize` bytes into RAM. The RAM side is a parametrised word interface with `LANES` bytes per write and `ram_ready` backpressure. It sits between BMP_ROM and BMP_RAM and replaces direct testbench file-to-RAM handling.

Parameters:
BYTE_WIDTH, 8, bits per ROM byte.
LANES, 4, bytes packed per RAM write; legal values 1, 2, 4.
ADDR_WIDTH, 20, ROM byte-address width.
MAX_BYTES, 786486, largest accepted `bfSize`; must be ≤ 2^ADDR_WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a load.
rom_rd_en  out  1  ROM read strobe; data returns one cycle later.
rom_addr  out  ADDR_WIDTH  ROM byte address.
rom_rdata  in  BYTE_WIDTH  ROM read data.
ram_wr_en  out  1  RAM write valid.
ram_addr  out  ADDR_WIDTH  RAM word address; byte address = ram_addr*LANES.
ram_wdata  out  LANES*BYTE_WIDTH  packed bytes; lower byte address in bits [7:0].
ram_ready  in  1  RAM accepts the write when ram_wr_en and ram_ready are both high.
busy  out  1  high from the cycle after start until done or err.
done  out  1  one-cycle pulse on successful completion.
err  out  1  sticky error flag; cleared by the next accepted start.
img_width  out  32  biWidth (bytes 18..21, little endian).
img_height  out  32  biHeight (bytes 22..25).
pix_offset  out  32  bfOffBits (bytes 10..13).
bit_count  out  16  biBitCount (bytes 28..29).

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-load aborts immediately. No further ROM reads or RAM writes occur, and the load does not resume after reset releases.
- States: IDLE → HDR → CHECK → COPY → DONE → IDLE; CHECK → ERR → IDLE.
- IDLE: start=1 clears err and the header registers and enters HDR. start is ignored in every other state.
- HDR: reads ROM bytes 0..29 on consecutive cycles, one read per cycle. Captures bytes 0..1 as the signature and bytes 2..5 as bfSize, all little endian, together with the header output fields. Moves to CHECK once byte 29 has been captured.
- CHECK: one cycle. Goes to ERR if any of these hold:
  - the signature is not 0x42 0x4D;
  - bfSize < 30 or bfSize > MAX_BYTES;
  - pix_offset ≥ bfSize.
  Otherwise goes to COPY.
- ERR: sets err=1 for one cycle of transit, returns to IDLE, and issues no RAM writes.
- COPY: re-reads bytes 0..bfSize-1 from address 0.
  - Bytes are packed into a LANES-byte word; ram_wr_en rises when the word is full or the last byte is packed.
  - A partial final word is zero-filled in the upper lanes.
  - Number of RAM writes = ceil(bfSize/LANES), with ram_addr running 0, 1, 2, …
  - Backpressure: while ram_wr_en=1 and ram_ready=0, ram_wr_en, ram_addr and ram_wdata hold stable. ROM reads stall with no byte lost or duplicated, including the in-flight ROM byte.
- DONE: done pulses one cycle after the final write is accepted, and busy falls in the same cycle.
- Header outputs hold their values until the next accepted start, on both success and error.
- With ram_ready held high, throughput is one byte per cycle.

Optional Feature:
- Macro: BMP_CHANNEL_SWAP_EN.
- When defined and bit_count==32, each pixel byte at address a ≥ pix_offset with (a−pix_offset) mod 4 ∈ {0,2} is exchanged with its partner (BGRA→RGBA). Header bytes and alpha are unchanged, and write count and latency are unchanged.
- When defined and bit_count≠32, the data is copied verbatim.
- When not defined, all data is copied verbatim and no swap logic is present.

Test Plan:
- 2×2 24-bpp BMP, bfSize=70, LANES=4, ram_ready=1 → 18 writes at addresses 0..17; word 17 = {8'h00, 8'h00, byte69, byte68}; img_width=2, img_height=2, pix_offset=54, bit_count=24; done pulses exactly once.
- Same image with byte0=0x41 → err=1, zero RAM writes, done never pulses, busy falls after CHECK.
- ram_ready toggled 0/1 every 3 cycles during COPY → RAM contents byte-identical to the ROM image, and wdata and addr stable across every stalled cycle.
- rst asserted at write 7 of 18, then released, then start → no write after reset; the second load completes with all 18 writes.
- start pulsed again during COPY → ignored; exactly 18 writes and one done.
- BMP_CHANNEL_SWAP_EN defined, 32-bpp 1×1 image with pixel bytes 11 22 33 44 at offset 54 → RAM bytes 54..57 = 33 22 11 44.
